// File: rtl/sram_ctrl.sv
// sram_ctrl: pin-level initiator for a small asynchronous SRAM.
// Turns single-word valid/ready requests into setup/pulse/hold write cycles and
// timed read cycles, with one transaction outstanding at a time.
// All SRAM pins come straight from flops.
// Optional feature: define SRAM_CTRL_INIT_CLEAR_EN to zero the whole array after reset
// before the first request is accepted.
module sram_ctrl #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned WE_PULSE = 2,
  parameter int unsigned RD_WAIT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {
    StIdle,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StRdActive
`ifdef SRAM_CTRL_INIT_CLEAR_EN
    ,
    StClrSetup,
    StClrPulse,
    StClrHold
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              drive_q, drive_d;
  logic              init_done_q;

`ifdef SRAM_CTRL_INIT_CLEAR_EN
  logic              init_done_d;

  // Clear-complete flag; cleared by reset so a reset mid-clear restarts at address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= init_done_d;
    end
  end
`else
  assign init_done_q = 1'b1;
`endif

  // Next-state sequencing; pin values are decoded from the next state so they are registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
`ifdef SRAM_CTRL_INIT_CLEAR_EN
    init_done_d = init_done_q;
`endif
    case (state_q)
      StIdle: begin
`ifdef SRAM_CTRL_INIT_CLEAR_EN
        if (!init_done_q) begin
          state_d = StClrSetup;
          addr_d  = '0;
          wdata_d = '0;
        end else
`endif
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = req_we ? StWrSetup : StRdActive;
        end
      end
      StWrSetup: begin
        cnt_d   = '0;
        state_d = StWrPulse;
      end
      StWrPulse: begin
        if (cnt_q == 8'(WE_PULSE - 1)) begin
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWrHold: begin
        state_d = StIdle;
      end
      StRdActive: begin
        if (cnt_q == 8'(RD_WAIT - 1)) begin
          state_d    = StIdle;
          rd_valid_d = 1'b1;
          rd_data_d  = sram_data;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef SRAM_CTRL_INIT_CLEAR_EN
      StClrSetup: begin
        cnt_d   = '0;
        state_d = StClrPulse;
      end
      StClrPulse: begin
        if (cnt_q == 8'(WE_PULSE - 1)) begin
          state_d = StClrHold;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StClrHold: begin
        // Stop at the all-ones address rather than wrapping.
        if (&addr_q) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StClrSetup;
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase

    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    drive_d = 1'b0;
    case (state_d)
      StWrSetup, StWrHold: begin
        ce_n_d  = 1'b0;
        drive_d = 1'b1;
      end
      StWrPulse: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        drive_d = 1'b1;
      end
      StRdActive: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
`ifdef SRAM_CTRL_INIT_CLEAR_EN
      StClrSetup, StClrHold: begin
        ce_n_d  = 1'b0;
        drive_d = 1'b1;
      end
      StClrPulse: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        drive_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // State, datapath and pin registers; async reset forces every pin inactive at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      drive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      drive_q    <= drive_d;
    end
  end

  assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign req_ready = (state_q == StIdle) && init_done_q;
  assign busy      = (state_q != StIdle) || !init_done_q;
  assign init_done = init_done_q;

endmodule
